// File: rtl/conv_bram_1d_result_drain.sv
// Result BRAM drain: reads RESULT_D channel BRAMs column by column and
// streams one beat per column through a 3-deep prefetch FIFO.
module conv_bram_1d_result_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int RESULT_W = 30,
  parameter int RESULT_D = 4,
  parameter int RESULT_RAM_ADDR_WIDTH =
    (RESULT_W > 1) ? $clog2(RESULT_W) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0] result_rdaddr,
  input  logic [DATA_WIDTH*RESULT_D-1:0] result_rddata,
  output logic [DATA_WIDTH*RESULT_D-1:0] out_data,
  output logic out_val,
  input  logic out_rdy,
  output logic out_last
);

  localparam int AW = RESULT_RAM_ADDR_WIDTH;
  localparam int BW = DATA_WIDTH * RESULT_D;
  localparam logic [AW-1:0] LAST_COL = AW'(RESULT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_col;
  logic inflight;

  logic [BW-1:0] fifo_data [3];
  logic [AW-1:0] fifo_col [3];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [1:0] count;

  logic accept;
  logic issue;
  logic push;
  logic pop;
  logic last_pop;
  logic [BW-1:0] head_data;
  logic [AW-1:0] head_col;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue depends only on registered occupancy, never on out_rdy.
  always_comb begin
    accept = (state == S_IDLE) && start;
    issue = (state == S_READ) &&
            ((3'(count) + 3'(inflight)) <= 3'd2);
    push = inflight;
    pop = out_val && out_rdy;
    last_pop = pop && out_last;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_READ;
      end
      S_READ: begin
        if (issue && (rd_addr == LAST_COL))
          state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_pop) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      rd_addr <= '0;
      rd_col <= '0;
      inflight <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      inflight <= issue;
      done <= last_pop;
      if (accept) begin
        rd_addr <= '0;
      end else if (issue) begin
        rd_addr <= rd_addr + AW'(1);
        rd_col <= rd_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        fifo_data[i] <= '0;
        fifo_col[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= result_rddata;
        fifo_col[wr_ptr] <= rd_col;
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10: count <= count + 2'd1;
        2'b01: count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head_data = fifo_data[rd_ptr];
    head_col = fifo_col[rd_ptr];
    busy = (state != S_IDLE);
    out_val = (count != 2'd0);
    out_data = out_val ? head_data : '0;
    out_last = out_val && (head_col == LAST_COL);
    result_rdaddr = {RESULT_D{rd_addr}};
  end

  fifo_no_overflow: assert property (
    @(posedge clk) disable iff (!reset)
    !(push && !pop && (count == 2'd3))
  );

endmodule

// File: tb/tb_conv_bram_1d_result_drain.sv
// Scoreboard bench for the result drain: a column-order reference queue
// is checked by an independent monitor; a RESULT_W=1 instance rides along.
module tb_conv_bram_1d_result_drain;

  localparam int DW = 8;
  localparam int W = 30;
  localparam int D = 4;
  localparam int AW = 5;
  localparam int BW = DW * D;
  localparam int AW1 = 1;

  typedef struct {
    logic [BW-1:0] data;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done, out_val, out_last;
  logic out_rdy = 1'b1;
  logic [AW*D-1:0] result_rdaddr;
  logic [BW-1:0] result_rddata = '0;
  logic [BW-1:0] out_data;

  logic start1 = 1'b0;
  logic busy1, done1, out_val1, out_last1;
  logic [AW1*D-1:0] result_rdaddr1;
  logic [BW-1:0] result_rddata1 = '0;
  logic [BW-1:0] out_data1;

  logic [7:0] mem [W][D];
  logic [7:0] mem1 [D];
  exp_t expq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 0;
  int first_cyc, last_cyc, done_cyc;
  int done_cnt = 0;
  int last_cnt = 0;
  int beats = 0;
  bit rand_rdy = 1'b0;
  bit rdy_set = 1'b1;

  conv_bram_1d_result_drain #(
    .DATA_WIDTH(DW), .RESULT_W(W), .RESULT_D(D)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done),
    .result_rdaddr(result_rdaddr),
    .result_rddata(result_rddata),
    .out_data(out_data), .out_val(out_val),
    .out_rdy(out_rdy), .out_last(out_last)
  );

  conv_bram_1d_result_drain #(
    .DATA_WIDTH(DW), .RESULT_W(1), .RESULT_D(D)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .busy(busy1), .done(done1),
    .result_rdaddr(result_rdaddr1),
    .result_rddata(result_rddata1),
    .out_data(out_data1), .out_val(out_val1),
    .out_rdy(1'b1), .out_last(out_last1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read BRAM models
  always @(posedge clk) begin
    for (int c = 0; c < D; c++) begin
      automatic int a = int'(result_rdaddr[c*AW +: AW]);
      automatic int a1 = int'(result_rdaddr1[c*AW1 +: AW1]);
      result_rddata[c*DW +: DW] <= (a < W) ? mem[a][c] : 8'h00;
      result_rddata1[c*DW +: DW] <= (a1 == 0) ? mem1[c] : 8'h00;
    end
  end

  always begin
    @(posedge clk);
    #2;
    out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_set;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stall hold
  bit stall_q = 1'b0;
  logic [BW-1:0] hold_d;
  logic hold_l;
  always @(negedge clk) begin
    if (!reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_val", 64'(out_val), 64'd1);
        chk("hold_data", 64'(out_data), 64'(hold_d));
        chk("hold_last", 64'(out_last), 64'(hold_l));
      end
      stall_q = out_val && !out_rdy;
      hold_d = out_data;
      hold_l = out_last;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_val && out_rdy) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_beat: got data 0x%0h, expected none",
                   out_data);
        end else begin
          automatic exp_t e = expq.pop_front();
          if (beats == 0) first_cyc = cyc;
          beats++;
          if (out_last) begin
            last_cnt++;
            last_cyc = cyc;
          end
          chk("beat_data", 64'(out_data), 64'(e.data));
          chk("beat_last", 64'(out_last), 64'(e.last));
        end
      end
    end
  end

  task automatic fill_mem(input bit pattern);
    for (int a = 0; a < W; a++)
      for (int c = 0; c < D; c++)
        mem[a][c] = pattern ? 8'((a * 4 + c) % 256)
                            : 8'($urandom_range(0, 255));
  endtask

  task automatic push_exp();
    expq.delete();
    for (int a = 0; a < W; a++) begin
      exp_t e;
      for (int c = 0; c < D; c++) e.data[c*DW +: DW] = mem[a][c];
      e.last = (a == W - 1);
      expq.push_back(e);
    end
    beats = 0;
    last_cnt = 0;
  endtask

  task automatic do_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic at_cycle(input int n);
    do @(negedge clk); while (cyc < t0 + n);
  endtask

  task automatic wait_done(input int maxc);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt == d0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done",
               maxc);
    end else begin
      chk("busy_at_done", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    fill_mem(1'b1);
    for (int c = 0; c < D; c++) mem1[c] = 8'($urandom_range(0, 255));
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_val", 64'(out_val), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr", 64'(result_rdaddr), 64'd0);
    chk("rst_val1", 64'(out_val1), 64'd0);
    repeat (3) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Full-rate drain
    rdy_set = 1'b1;
    push_exp();
    do_start();
    at_cycle(1);
    chk("c1_busy", 64'(busy), 64'd1);
    chk("c1_addr", 64'(result_rdaddr[AW-1:0]), 64'd0);
    at_cycle(2);
    chk("c2_val", 64'(out_val), 64'd0);
    wait_done(100);
    chk("fr_first", 64'(first_cyc - t0), 64'd3);
    chk("fr_lastcyc", 64'(last_cyc - t0), 64'd32);
    chk("fr_done", 64'(done_cyc - t0), 64'd33);
    chk("fr_beats", 64'(beats), 64'(W));
    chk("fr_lastcnt", 64'(last_cnt), 64'd1);

    // Back-pressure for cycles 3..12
    rdy_set = 1'b0;
    fill_mem(1'b0);
    push_exp();
    do_start();
    at_cycle(12);
    chk("bp_addr", 64'(result_rdaddr[AW-1:0]), 64'd3);
    chk("bp_val", 64'(out_val), 64'd1);
    chk("bp_col0", 64'(out_data), 64'(expq[0].data));
    rdy_set = 1'b1;
    wait_done(100);
    chk("bp_first", 64'(first_cyc - t0), 64'd13);
    chk("bp_lastcyc", 64'(last_cyc - t0), 64'd42);
    chk("bp_done", 64'(done_cyc - t0), 64'd43);
    chk("bp_beats", 64'(beats), 64'(W));

    // start while busy is ignored
    fill_mem(1'b0);
    push_exp();
    d0 = done_cnt;
    do_start();
    at_cycle(9);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(100);
    repeat (10) @(negedge clk);
    chk("sb_donecnt", 64'(done_cnt - d0), 64'd1);
    chk("sb_beats", 64'(beats), 64'(W));
    chk("sb_done", 64'(done_cyc - t0), 64'd33);

    // Reset mid-drain, then a clean drain
    fill_mem(1'b0);
    push_exp();
    do_start();
    at_cycle(14);
    @(posedge clk);
    #1;
    reset = 1'b0;
    expq.delete();
    #1;
    chk("mr_val", 64'(out_val), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_done", 64'(done), 64'd0);
    chk("mr_addr", 64'(result_rdaddr), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    fill_mem(1'b0);
    push_exp();
    do_start();
    wait_done(100);
    chk("pr_first", 64'(first_cyc - t0), 64'd3);
    chk("pr_done", 64'(done_cyc - t0), 64'd33);
    chk("pr_beats", 64'(beats), 64'(W));

    // RESULT_W=1 instance
    begin
      logic [BW-1:0] e1;
      for (int c = 0; c < D; c++) e1[c*DW +: DW] = mem1[c];
      @(posedge clk);
      #1;
      start1 = 1'b1;
      t0 = cyc;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      at_cycle(2);
      chk("w1_c2_val", 64'(out_val1), 64'd0);
      at_cycle(3);
      chk("w1_val", 64'(out_val1), 64'd1);
      chk("w1_last", 64'(out_last1), 64'd1);
      chk("w1_data", 64'(out_data1), 64'(e1));
      at_cycle(4);
      chk("w1_done", 64'(done1), 64'd1);
      chk("w1_busy", 64'(busy1), 64'd0);
      chk("w1_val_after", 64'(out_val1), 64'd0);
    end

    // Random ready, random contents
    rand_rdy = 1'b1;
    for (int k = 0; k < 200; k++) begin
      fill_mem(1'b0);
      push_exp();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_start();
      wait_done(2000);
      chk("rnd_lastcnt", 64'(last_cnt), 64'd1);
      chk("rnd_left", 64'(expq.size()), 64'd0);
    end
    rand_rdy = 1'b0;
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
